xintf_master_ctrl: RTL and testbench

//  FPGA-side XINTF bus initiator: the requesting end of the DSP XINTF zone-B slave protocol.

---
 rtl/xintf_pkg.sv | 16 +
 rtl/xintf_phase_cnt.sv | 27 ++
 rtl/xintf_master_ctrl.sv | 128 ++++++++++++
 tb/tb_xintf_master_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xintf_pkg.sv
// xintf_pkg: shared XINTF bus widths, the high-impedance data constant and the initiator FSM states.
package xintf_pkg;

    localparam int XINTF_AW = 9;
    localparam int XINTF_DW = 16;

    localparam logic [XINTF_DW-1:0] XD_HIZ = 16'hZZZZ;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_TRAIL  = 2'd3
    } xintf_state_e;

endpackage

// File: rtl/xintf_phase_cnt.sv
// xintf_phase_cnt: per-phase clock counter. Restarts at 0 on load and flags the last clock of the phase.
module xintf_phase_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_len,
    output logic             o_tc
);

    logic [CNT_W-1:0] cnt;

    // Saturates on the terminal count so a stalled phase keeps reporting its last clock.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt <= '0;
        end else if (i_load) begin
            cnt <= '0;
        end else if (!o_tc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign o_tc = (cnt == i_len - CNT_W'(1));

endmodule

// File: rtl/xintf_master_ctrl.sv
// xintf_master_ctrl: XINTF zone-B bus initiator turning single-word requests into LEAD/ACTIVE/TRAIL cycles.
// Defining XINTF_READY_EN adds i_Z_B_XREADY wait states on the last ACTIVE clock.
module xintf_master_ctrl
    import xintf_pkg::*;
#(
    parameter int LEAD_CYC   = 2,
    parameter int ACTIVE_CYC = 6,
    parameter int TRAIL_CYC  = 1,
    parameter int CNT_W      = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_req,
    input  logic                i_req_wr,
    input  logic [XINTF_AW-1:0] i_req_addr,
    input  logic [XINTF_DW-1:0] i_req_wdata,
    output logic                o_req_ack,
    output logic                o_busy,
    output logic                o_rd_valid,
    output logic [XINTF_DW-1:0] o_rd_data,
    output logic                o_nZ_B_CS,
    output logic                o_nZ_B_WE,
    output logic [XINTF_AW-1:0] o_Z_B_XA,
    inout  wire  [XINTF_DW-1:0] io_Z_B_XD,
`ifdef XINTF_READY_EN
    input  logic                i_Z_B_XREADY,
`endif
    output xintf_state_e        o_dbg_state
);

    // Request handshake: i_req is a level, taken only on a clock where the FSM is IDLE; acceptance
    // is the one-clock o_req_ack pulse. While o_busy is high i_req is ignored, so a held i_req is
    // taken again on the first IDLE clock after TRAIL.
    xintf_state_e          state;
    logic                  wr_q;
    logic [XINTF_AW-1:0]   addr_q;
    logic [XINTF_DW-1:0]   wdata_q;
    logic [XINTF_DW-1:0]   cap_q;
    logic                  cap_pend;
    logic [CNT_W-1:0]      phase_len;
    logic                  phase_tc;
    logic                  ready;
    logic                  advance;

`ifdef XINTF_READY_EN
    assign ready = i_Z_B_XREADY;
`else
    assign ready = 1'b1;
`endif

    always_comb begin
        phase_len = CNT_W'(1);
        case (state)
            ST_LEAD:   phase_len = CNT_W'(LEAD_CYC);
            ST_ACTIVE: phase_len = CNT_W'(ACTIVE_CYC);
            ST_TRAIL:  phase_len = CNT_W'(TRAIL_CYC);
            default:   phase_len = CNT_W'(1);
        endcase
    end

    assign advance = (state != ST_IDLE) && phase_tc && ((state != ST_ACTIVE) || ready);

    xintf_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load ((state == ST_IDLE) || advance),
        .i_len  (phase_len),
        .o_tc   (phase_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cap_q      <= '0;
            cap_pend   <= 1'b0;
            o_req_ack  <= 1'b0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
        end else begin
            o_req_ack  <= 1'b0;
            o_rd_valid <= cap_pend;
            cap_pend   <= 1'b0;
            if (cap_pend) begin
                o_rd_data <= cap_q;
            end
            case (state)
                ST_IDLE: begin
                    if (i_req) begin
                        wr_q      <= i_req_wr;
                        addr_q    <= i_req_addr;
                        wdata_q   <= i_req_wdata;
                        o_req_ack <= 1'b1;
                        state     <= ST_LEAD;
                    end
                end
                ST_LEAD: begin
                    if (advance) state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    // Read data is taken on the ACTIVE clock that ends the phase, published one clock later.
                    if (advance) begin
                        state <= ST_TRAIL;
                        if (!wr_q) begin
                            cap_q    <= io_Z_B_XD;
                            cap_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (advance) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (state != ST_IDLE);
    assign o_nZ_B_CS   = (state != ST_ACTIVE);
    assign o_nZ_B_WE   = (state == ST_IDLE) || !wr_q;
    assign o_Z_B_XA    = (state != ST_IDLE) ? addr_q : '0;
    assign io_Z_B_XD   = ((state != ST_IDLE) && wr_q) ? wdata_q : {XINTF_DW{1'bz}};
    assign o_dbg_state = state;

endmodule

// File: tb/tb_xintf_master_ctrl.sv
// tb_xintf_master_ctrl: drives the initiator against a behavioural XINTF RAM slave and checks
// every clock against a cycle-offset model of the access timeline.
`timescale 1ns/1ps
module tb_xintf_master_ctrl;
    import xintf_pkg::*;

    localparam int L = 2;
    localparam int A = 6;
    localparam int T = 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        req = 1'b0, req_wr = 1'b0;
    logic [8:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        xready = 1'b1;
    logic        ready_mode = 1'b0, ready_force = 1'b1;
    logic        ack, busy, rdv, ncs, nwe;
    logic [15:0] rd_data;
    logic [8:0]  xa;
    tri1  [15:0] xd;
    xintf_state_e dbg_state;

    logic        pl_en = 1'b0;
    logic [8:0]  pl_addr = '0;
    logic [15:0] pl_data = '0;
    logic [15:0] slave_ram [512];
    logic [15:0] mram [512];

    xintf_master_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst_n),
        .i_req        (req),
        .i_req_wr     (req_wr),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_req_ack    (ack),
        .o_busy       (busy),
        .o_rd_valid   (rdv),
        .o_rd_data    (rd_data),
        .o_nZ_B_CS    (ncs),
        .o_nZ_B_WE    (nwe),
        .o_Z_B_XA     (xa),
        .io_Z_B_XD    (xd),
`ifdef XINTF_READY_EN
        .i_Z_B_XREADY (xready),
`endif
        .o_dbg_state  (dbg_state)
    );

    // XINTF RAM slave: drives data while selected for a read, stores on each selected write clock.
    assign xd = (!ncs && nwe) ? slave_ram[xa] : 16'hzzzz;
    always @(posedge clk) begin
        if (pl_en) slave_ram[pl_addr] <= pl_data;
        else if (!ncs && !nwe) slave_ram[xa] <= xd;
    end

    always @(negedge clk) xready <= ready_mode ? ($urandom_range(0, 3) != 0) : ready_force;

    // ---------------- reference model ----------------
    int          m_off;
    logic        m_wr, m_ack, m_rdv;
    logic [8:0]  m_addr;
    logic [15:0] m_wdata, m_rdata;
    logic [15:0] exp_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_off   <= -1;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_ack   <= 1'b0;
            m_rdv   <= 1'b0;
            m_rdata <= '0;
            exp_q.delete();
        end else begin
            m_ack <= 1'b0;
            m_rdv <= 1'b0;
            if (pl_en) mram[pl_addr] <= pl_data;
            if (m_off < 0) begin
                if (req) begin
                    m_off   <= 0;
                    m_wr    <= req_wr;
                    m_addr  <= req_addr;
                    m_wdata <= req_wdata;
                    m_ack   <= 1'b1;
                    if (!req_wr) exp_q.push_back(mram[req_addr]);
                end
            end else if (m_off == L + A + T - 1) begin
                m_off <= -1;
                if (!m_wr) begin
                    m_rdv   <= 1'b1;
                    m_rdata <= mram[m_addr];
                end else begin
                    mram[m_addr] <= m_wdata;
                end
            end else if (!(m_off == L + A - 1 && !xready)) begin
                m_off <= m_off + 1;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_pass = 0, n_tot = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int t_ack = 0, t_rdv = 0, n_rdv = 0, ncs_total = 0;
    int ncs_run = 0, ncs_last = 0, wr_run = 0, wr_last = 0, hi_run = 0, hi_last = 0;
    int ack_t [$];
    logic        e_busy, e_act;
    logic [15:0] e_xd;

    always @(negedge clk) begin
        e_busy = (m_off >= 0);
        e_act  = (m_off >= L) && (m_off < L + A);
        e_xd   = (e_busy && m_wr) ? m_wdata : (e_act ? mram[m_addr] : 16'hFFFF);
        chk("busy", busy, e_busy);
        chk("ack", ack, m_ack);
        chk("ncs", ncs, !e_act);
        chk("nwe", nwe, !(e_busy && m_wr));
        chk("xa", xa, e_busy ? m_addr : 9'd0);
        chk("xd", xd, e_xd);
        chk("rd_valid", rdv, m_rdv);
        chk("rd_data", rd_data, m_rdata);
        chk("dbg_idle", dbg_state == ST_IDLE, !e_busy);
        if (rdv) begin
            chk("rd_q_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("rd_q_data", rd_data, exp_q.pop_front());
            t_rdv = cyc;
            n_rdv++;
        end
        if (ack) begin
            t_ack = cyc;
            ack_t.push_back(cyc);
        end
        if (!ncs) begin
            if (ncs_run == 0) hi_last = hi_run;
            ncs_run++;
            ncs_total++;
            hi_run = 0;
        end else begin
            if (ncs_run > 0) ncs_last = ncs_run;
            ncs_run = 0;
            hi_run++;
        end
        if (!ncs && !nwe) wr_run++;
        else begin
            if (wr_run > 0) wr_last = wr_run;
            wr_run = 0;
        end
    end

    // ---------------- driver tasks (entered and left on a falling edge) ----------------
    task automatic do_req(input logic wr, input logic [8:0] a, input logic [15:0] d, input logic keep);
        int n;
        n = 0;
        req = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 100);
        chk("ack_seen", ack, 1);
        if (!keep) begin
            req = 1'b0;
            req_wr = 1'($urandom); req_addr = 9'($urandom); req_wdata = 16'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_seen", busy, 0);
    endtask

    task automatic preload(input logic [8:0] a, input logic [15:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int saved;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ncs", ncs, 1);
        chk("rst_nwe", nwe, 1);
        chk("rst_xd", xd, 16'hFFFF);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_xa", xa, 9'h000);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        saved = ncs_total;
        repeat (10) @(negedge clk);
        chk("idle_no_cs", ncs_total, saved);

        for (int i = 0; i < 512; i++) preload(9'(i), 16'($urandom));

        // single write
        do_req(1'b1, 9'h012, 16'hA5C3, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("wr_cs_len", ncs_last, 6);
        chk("wr_we_len", wr_last, 6);
        chk("wr_ram", slave_ram[9'h012], 16'hA5C3);

        // single read
        preload(9'h1FF, 16'h1234);
        do_req(1'b0, 9'h1FF, 16'h0000, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("rd_latency", t_rdv - t_ack, 9);
        chk("rd_value", rd_data, 16'h1234);

        // back-to-back writes with i_req held
        ack_t.delete();
        do_req(1'b1, 9'd0, 16'h1111, 1'b1);
        do_req(1'b1, 9'd1, 16'h2222, 1'b1);
        do_req(1'b1, 9'd2, 16'h3333, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("b2b_acks", ack_t.size(), 3);
        if (ack_t.size() == 3) begin
            chk("b2b_gap1", ack_t[1] - ack_t[0], 10);
            chk("b2b_gap2", ack_t[2] - ack_t[1], 10);
        end
        chk("b2b_cs_high", hi_last >= 1, 1);
        chk("b2b_ram2", slave_ram[9'd2], 16'h3333);

        // reset on the third ACTIVE clock of a read
        saved = n_rdv;
        do_req(1'b0, 9'h0F0, 16'h0000, 1'b0);
        repeat (L + 2) @(negedge clk);
        chk("mid_cs_low", ncs, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_ncs", ncs, 1);
        chk("mid_rst_xd", xd, 16'hFFFF);
        chk("mid_rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("mid_no_rdv", n_rdv, saved);
        preload(9'h055, 16'hBEEF);
        do_req(1'b0, 9'h055, 16'h0000, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("post_rst_rd", rd_data, 16'hBEEF);

`ifdef XINTF_READY_EN
        preload(9'h0AA, 16'h5A5A);
        #1 ready_force = 1'b0;
        @(negedge clk);
        do_req(1'b0, 9'h0AA, 16'h0000, 1'b0);
        repeat (10) @(negedge clk);
        #1 ready_force = 1'b1;
        @(negedge clk);
        wait_idle();
        @(negedge clk);
        chk("rdy_cs_len", ncs_last, 10);
        chk("rdy_value", rd_data, 16'h5A5A);
        ready_mode = 1'b1;
`endif

        // randomized traffic
        for (int k = 0; k < 40; k++) begin
            logic keep;
            keep = ($urandom_range(0, 3) == 0);
            do_req(1'($urandom), 9'($urandom), 16'($urandom), keep);
            if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        req = 1'b0;
        wait_idle();
        ready_mode = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1);
    end

endmodule
